// File: rtl/enc_pkg.sv
// Shared constants and helpers for the sticky request encoder.
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic logic [63:0] onehot(input int unsigned idx,
                                           input int unsigned n);
        return (idx < n) ? (64'd1 << idx) : 64'd0;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Lowest-set-index finder with an any-found flag.
module prio_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder_q.sv
// Sticky request latch presenting one encoded index at a time
// on a registered valid/ready output, fixed-priority or round-robin.
module req_encoder_q
    import enc_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int RR = 0,
    localparam int W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         flush,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         overflow
);

    localparam logic [W:0] NW = (W + 1)'(N);

    logic [N-1:0]   pend_q, pend_d;
    logic           vld_q, vld_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           ovf_q, ovf_d;

    logic [N-1:0]   pres_oh;
    logic [N-1:0]   kept;
    logic [N-1:0]   cand;
    logic [N-1:0]   rot;
    logic [2*N-1:0] dbl;
    logic [W-1:0]   base;
    logic [W-1:0]   pick;
    logic [W-1:0]   sel;
    logic [W:0]     sum;
    logic           hs;
    logic           load;
    logic           found;

    assign hs   = vld_q & out_ready;
    assign load = ~vld_q | hs;
    assign base = (RR == MODE_RR) ? ptr_q : '0;

    // The presented bit is masked out even if re-requested, so it
    // waits behind the other candidates instead of repeating.
    always_comb begin
        pres_oh = vld_q ? N'(onehot(32'(idx_q), N)) : '0;
        kept    = pend_q & ~(hs ? pres_oh : '0);
        cand    = (kept | req) & ~pres_oh;
    end

    // Rotate right by the search base so a plain lowest-index pick
    // yields the first candidate at or after it, with wrap.
    assign dbl = {cand, cand};
    assign rot = N'(dbl >> base);

    prio_pick #(.N(N)) u_pick (
        .vec_i   (rot),
        .idx_o   (pick),
        .found_o (found)
    );

    always_comb begin
        sum = {1'b0, pick} + {1'b0, base};
        sel = (sum >= NW) ? W'(sum - NW) : W'(sum);
    end

    always_comb begin
        pend_d = flush ? '0 : (kept | req);
        ovf_d  = ~flush & (|(req & kept));
        vld_d  = vld_q;
        idx_d  = idx_q;
        ptr_d  = ptr_q;
        if (flush) begin
            vld_d = 1'b0;
        end else begin
            if (load) begin
                vld_d = found;
                if (found) begin
                    idx_d = sel;
                end
            end
            if (RR == MODE_RR && hs) begin
                ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            ptr_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = vld_q;
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_req_encoder_q.sv
// Bench for req_encoder_q: fixed-priority N=4 and round-robin N=5
// instances checked each cycle against a set-based reference model.
module tb_req_encoder_q;

    typedef struct {
        logic [63:0] pend;
        bit          vld;
        int          idx;
        int          ptr;
        bit          ovf;
    } mdl_t;

    logic       clk;
    logic       rst_n;

    logic [3:0] a_req;
    logic       a_fl, a_rdy;
    logic       a_vld, a_ovf;
    logic [1:0] a_idx;
    logic [3:0] a_pend;

    logic [4:0] b_req;
    logic       b_fl, b_rdy;
    logic       b_vld, b_ovf;
    logic [2:0] b_idx;
    logic [4:0] b_pend;

    int   n_cmp;
    int   n_bad;
    mdl_t ma;
    mdl_t mb;
    int   rr_exp [6] = '{0, 1, 2, 3, 4, 0};

    req_encoder_q #(.N(4), .RR(0)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (a_req),
        .flush     (a_fl),
        .out_ready (a_rdy),
        .out_valid (a_vld),
        .out_idx   (a_idx),
        .pending   (a_pend),
        .overflow  (a_ovf)
    );

    req_encoder_q #(.N(5), .RR(1)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (b_req),
        .flush     (b_fl),
        .out_ready (b_rdy),
        .out_valid (b_vld),
        .out_idx   (b_idx),
        .pending   (b_pend),
        .overflow  (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mreset();
        mdl_t m;
        m.pend = '0;
        m.vld  = 1'b0;
        m.idx  = 0;
        m.ptr  = 0;
        m.ovf  = 1'b0;
        return m;
    endfunction

    // One clock of the request set: serve, re-collect, then choose.
    function automatic mdl_t mstep(mdl_t m, logic [63:0] rq_in,
                                   bit fl, bit rdy, int n, bit rr);
        mdl_t        nx;
        logic [63:0] rq;
        logic [63:0] kept;
        logic [63:0] avail;
        bit          hs;
        bit          found;
        nx   = m;
        rq   = rq_in & ((64'd1 << n) - 64'd1);
        hs   = m.vld && rdy;
        kept = m.pend;
        if (hs) kept[m.idx] = 1'b0;
        nx.ovf = !fl && ((rq & kept) != 64'd0);
        if (fl) begin
            nx.pend = '0;
            nx.vld  = 1'b0;
            return nx;
        end
        nx.pend = kept | rq;
        if (hs && rr) nx.ptr = (m.idx + 1) % n;
        if (!m.vld || hs) begin
            avail = kept | rq;
            if (m.vld) avail[m.idx] = 1'b0;
            found = 1'b0;
            for (int k = 0; k < n; k++) begin
                int c;
                c = rr ? (m.ptr + k) % n : k;
                if (!found && avail[c]) begin
                    found  = 1'b1;
                    nx.idx = c;
                end
            end
            nx.vld = found;
        end
        return nx;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) begin
        ma = mreset();
        mb = mreset();
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, 64'(a_req), a_fl, a_rdy, 4, 1'b0);
            mb = mstep(mb, 64'(b_req), b_fl, b_rdy, 5, 1'b1);
        end
        #1;
        chk("a.valid", 64'(a_vld), 64'(ma.vld));
        chk("a.idx", 64'(a_idx), 64'(ma.idx));
        chk("a.pending", 64'(a_pend), ma.pend);
        chk("a.overflow", 64'(a_ovf), 64'(ma.ovf));
        chk("b.valid", 64'(b_vld), 64'(mb.vld));
        chk("b.idx", 64'(b_idx), 64'(mb.idx));
        chk("b.pending", 64'(b_pend), mb.pend);
        chk("b.overflow", 64'(b_ovf), 64'(mb.ovf));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ma    = mreset();
        mb    = mreset();
        rst_n = 1'b0;
        a_req = '0; a_fl = 1'b0; a_rdy = 1'b0;
        b_req = '0; b_fl = 1'b0; b_rdy = 1'b0;
        repeat (2) tick();
        chk("rst.valid", 64'(a_vld), 64'd0);
        chk("rst.pending", 64'(a_pend), 64'd0);
        chk("rst.idx", 64'(a_idx), 64'd0);
        chk("rst.overflow", 64'(a_ovf), 64'd0);
        rst_n = 1'b1;

        // fixed priority drain
        a_req = 4'b1010; a_rdy = 1'b1;
        tick();
        chk("fp.idx1", 64'(a_idx), 64'd1);
        chk("fp.pend1", 64'(a_pend), 64'b1010);
        a_req = '0;
        tick();
        chk("fp.idx3", 64'(a_idx), 64'd3);
        chk("fp.pend3", 64'(a_pend), 64'b1000);
        tick();
        chk("fp.idle", 64'(a_vld), 64'd0);
        chk("fp.empty", 64'(a_pend), 64'd0);

        // backpressure
        a_rdy = 1'b0; a_req = 4'b0110;
        tick();
        chk("bp.idx", 64'(a_idx), 64'd1);
        a_req = '0;
        repeat (2) begin
            tick();
            chk("bp.hold", 64'(a_idx), 64'd1);
            chk("bp.valid", 64'(a_vld), 64'd1);
        end
        a_rdy = 1'b1;
        tick();
        chk("bp.next", 64'(a_idx), 64'd2);
        tick();
        chk("bp.idle", 64'(a_vld), 64'd0);

        // re-request of the bit being handed over
        a_rdy = 1'b0; a_req = 4'b1100;
        tick();
        chk("rq.idx2", 64'(a_idx), 64'd2);
        a_rdy = 1'b1; a_req = 4'b0100;
        tick();
        chk("rq.idx3", 64'(a_idx), 64'd3);
        chk("rq.pend", 64'(a_pend), 64'b1100);
        chk("rq.ovf", 64'(a_ovf), 64'd0);
        a_req = '0;
        tick();
        chk("rq.again", 64'(a_idx), 64'd2);
        chk("rq.pend2", 64'(a_pend), 64'b0100);
        tick();
        chk("rq.idle", 64'(a_vld), 64'd0);

        // overflow on a pending, non-presented bit
        a_rdy = 1'b0; a_req = 4'b0010;
        tick();
        a_req = 4'b0001;
        tick();
        chk("ov.first", 64'(a_ovf), 64'd0);
        tick();
        chk("ov.pulse", 64'(a_ovf), 64'd1);
        chk("ov.pend", 64'(a_pend), 64'b0011);
        a_req = '0;
        tick();
        chk("ov.clear", 64'(a_ovf), 64'd0);
        a_rdy = 1'b1;
        repeat (2) tick();
        a_rdy = 1'b0;

        // asynchronous reset mid-operation
        a_req = 4'b1011;
        tick();
        chk("ar.pend", 64'(a_pend), 64'b1011);
        a_req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid", 64'(a_vld), 64'd0);
        chk("ar.pending", 64'(a_pend), 64'd0);
        chk("ar.idx", 64'(a_idx), 64'd0);
        chk("ar.overflow", 64'(a_ovf), 64'd0);
        tick();
        rst_n = 1'b1;

        // round-robin, N=5
        b_req = 5'b11111; b_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr.seq", 64'(b_idx), 64'(rr_exp[i]));
        end
        b_fl = 1'b1;
        tick();
        chk("rr.fl.valid", 64'(b_vld), 64'd0);
        chk("rr.fl.pend", 64'(b_pend), 64'd0);
        chk("rr.fl.ovf", 64'(b_ovf), 64'd0);
        b_fl = 1'b0; b_req = '0;
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            a_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            b_req = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            a_fl  = ($urandom_range(0, 40) == 0);
            b_fl  = ($urandom_range(0, 40) == 0);
            a_rdy = ($urandom_range(0, 3) != 0);
            b_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        a_req = '0; b_req = '0; a_fl = 1'b0; b_fl = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
